// File: rtl/misr.sv
// Multiple-input signature register: accepts a word count, folds that many CUT
// response words into an LFSR-style signature and hands it back to the controller.
module misr #(
  parameter int unsigned MISR_MSG_BITS = 32,
  parameter int unsigned COUNT_BITS    = 32,
  parameter int unsigned T1            = 1,
  parameter int unsigned T2            = 5,
  parameter int unsigned T3            = 6,
  parameter int unsigned T4            = 31
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_val,
  output logic                     req_rdy,
  input  logic [COUNT_BITS-1:0]    req_msg,
  input  logic                     cut_val,
  output logic                     cut_rdy,
  input  logic [MISR_MSG_BITS-1:0] cut_msg,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic [MISR_MSG_BITS-1:0] resp_msg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMPRESS = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t                   state, state_n;
  logic [MISR_MSG_BITS-1:0] sig, sig_n;
  logic [COUNT_BITS-1:0]    remaining, remaining_n;
  logic                     fb;
  logic [MISR_MSG_BITS-1:0] sig_next_word;

  // Old MSB falls off the top; the tap parity enters at bit 0 before the XOR-in.
  assign fb            = sig[T1] ^ sig[T2] ^ sig[T3] ^ sig[T4];
  assign sig_next_word = {sig[MISR_MSG_BITS-2:0], fb} ^ cut_msg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sig       <= '0;
      remaining <= '0;
    end else begin
      state     <= state_n;
      sig       <= sig_n;
      remaining <= remaining_n;
    end
  end

  always_comb begin
    state_n     = state;
    sig_n       = sig;
    remaining_n = remaining;
    case (state)
      IDLE: begin
        if (req_val) begin
          sig_n       = '0;
          remaining_n = req_msg;
          state_n     = (req_msg != '0) ? COMPRESS : DONE;
        end
      end
      COMPRESS: begin
        if (cut_val) begin
          sig_n = sig_next_word;
          if (remaining != '0) begin
            remaining_n = remaining - COUNT_BITS'(1);
          end
          if (remaining == COUNT_BITS'(1)) begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        if (resp_rdy) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Moore outputs: decoded from registered state only.
  always_comb begin
    req_rdy  = 1'b0;
    cut_rdy  = 1'b0;
    resp_val = 1'b0;
    resp_msg = '0;
    case (state)
      IDLE:     req_rdy = 1'b1;
      COMPRESS: cut_rdy = 1'b1;
      DONE: begin
        resp_val = 1'b1;
        resp_msg = sig;
      end
      default:  req_rdy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_misr.sv
// Directed bench for misr: stimulus pushes expected signatures into a queue,
// an independent monitor pops and compares whenever resp_val is presented.
module tb_misr;

  logic        clk;
  logic        reset;
  logic        req_val;
  logic        req_rdy;
  logic [31:0] req_msg;
  logic        cut_val;
  logic        cut_rdy;
  logic [31:0] cut_msg;
  logic        resp_val;
  logic        resp_rdy;
  logic [31:0] resp_msg;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  misr #(
    .MISR_MSG_BITS(32),
    .COUNT_BITS   (32),
    .T1           (1),
    .T2           (5),
    .T3           (6),
    .T4           (31)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_val (req_val),
    .req_rdy (req_rdy),
    .req_msg (req_msg),
    .cut_val (cut_val),
    .cut_rdy (cut_rdy),
    .cut_msg (cut_msg),
    .resp_val(resp_val),
    .resp_rdy(resp_rdy),
    .resp_msg(resp_msg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [31:0] count);
    req_val = 1'b1;
    req_msg = count;
    chk("req_rdy_before_req", {63'd0, req_rdy}, 64'd1);
    tick();
    req_val = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    cut_val = 1'b1;
    cut_msg = w;
    chk("cut_rdy_before_word", {63'd0, cut_rdy}, 64'd1);
    tick();
    cut_val = 1'b0;
  endtask

  task automatic wait_resp(input int max_cycles);
    for (int i = 0; i < max_cycles && !resp_val; i++) tick();
    chk("resp_val_within_budget", {63'd0, resp_val}, 64'd1);
  endtask

  task automatic release_resp();
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    chk("resp_val_drops", {63'd0, resp_val}, 64'd0);
    chk("req_rdy_after_resp", {63'd0, req_rdy}, 64'd1);
  endtask

  // Monitor: pop on the rising of resp_val, compare every cycle it stays high.
  initial begin
    logic        prev_val;
    logic [31:0] cur_exp;
    prev_val = 1'b0;
    cur_exp  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_val = 1'b0;
      end else begin
        if (resp_val) begin
          if (!prev_val) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_resp: got 0x%0h with empty queue at %0t", resp_msg, $time);
              cur_exp = resp_msg;
            end else begin
              cur_exp = exp_q.pop_front();
            end
          end
          chk("resp_msg", {32'd0, resp_msg}, {32'd0, cur_exp});
        end
        prev_val = resp_val;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    req_val  = 1'b0;
    req_msg  = '0;
    cut_val  = 1'b0;
    cut_msg  = '0;
    resp_rdy = 1'b0;
    tick();
    tick();
    chk("rst_req_rdy",  {63'd0, req_rdy},  64'd1);
    chk("rst_cut_rdy",  {63'd0, cut_rdy},  64'd0);
    chk("rst_resp_val", {63'd0, resp_val}, 64'd0);
    chk("rst_resp_msg", {32'd0, resp_msg}, 64'd0);
    reset = 1'b0;
    tick();

    // Test 1: two words, resp_val exactly three cycles after the request.
    exp_q.push_back(32'h0000_0000);
    do_req(32'd2);
    chk("t1_compress_no_resp", {63'd0, resp_val}, 64'd0);
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    chk("t1_resp_val_latency", {63'd0, resp_val}, 64'd1);
    chk("t1_cut_rdy_done",     {63'd0, cut_rdy},  64'd0);
    release_resp();

    // Test 2: MSB drop with feedback from bit 31.
    exp_q.push_back(32'h0000_0001);
    do_req(32'd2);
    send_word(32'h8000_0000);
    send_word(32'h0000_0000);
    chk("t2_resp_val", {63'd0, resp_val}, 64'd1);
    release_resp();

    // Test 2b: feedback from tap bit 6.
    exp_q.push_back(32'h0000_0081);
    do_req(32'd2);
    send_word(32'h0000_0040);
    send_word(32'h0000_0000);
    wait_resp(2);
    release_resp();

    // Test 3: cut_val toggling over four words, then five cycles of backpressure.
    exp_q.push_back(32'hF000_0044);
    do_req(32'd4);
    send_word(32'h0000_0001);
    tick();
    send_word(32'h0000_0003);
    tick();
    send_word(32'h0000_0020);
    tick();
    chk("t3_still_compress", {63'd0, cut_rdy},  64'd1);
    chk("t3_no_early_resp",  {63'd0, resp_val}, 64'd0);
    send_word(32'hF000_0000);
    chk("t3_done_after_4th", {63'd0, resp_val}, 64'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("t3_hold_val", {63'd0, resp_val}, 64'd1);
    chk("t3_hold_msg", {32'd0, resp_msg}, 64'hF000_0044);
    release_resp();

    // Test 4: zero count with cut_val asserted throughout.
    exp_q.push_back(32'h0000_0000);
    cut_val = 1'b1;
    cut_msg = 32'hFFFF_FFFF;
    do_req(32'd0);
    chk("t4_done_next_cycle", {63'd0, resp_val}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      chk("t4_cut_rdy_low", {63'd0, cut_rdy}, 64'd0);
      tick();
    end
    release_resp();
    cut_val = 1'b0;

    // Test 5: reset during compaction, outputs return asynchronously.
    do_req(32'd10);
    send_word(32'h1234_5678);
    send_word(32'h9ABC_DEF0);
    send_word(32'h0F0F_F0F0);
    reset = 1'b1;
    #1;
    chk("t5_async_req_rdy",  {63'd0, req_rdy},  64'd1);
    chk("t5_async_cut_rdy",  {63'd0, cut_rdy},  64'd0);
    chk("t5_async_resp_val", {63'd0, resp_val}, 64'd0);
    chk("t5_async_resp_msg", {32'd0, resp_msg}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    exp_q.push_back(32'hDEAD_BEEF);
    do_req(32'd1);
    send_word(32'hDEAD_BEEF);
    chk("t5_resp_val", {63'd0, resp_val}, 64'd1);
    release_resp();

    // Test 6: back-to-back signatures with a one-cycle gap.
    exp_q.push_back(32'h0000_000F);
    do_req(32'd1);
    send_word(32'h0000_000F);
    release_resp();
    exp_q.push_back(32'h4444_4445);
    do_req(32'd2);
    send_word(32'hA5A5_A5A5);
    send_word(32'h0F0F_0F0F);
    chk("t6_resp_val", {63'd0, resp_val}, 64'd1);
    release_resp();

    tick();
    tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
